// File: rtl/mem_controller.sv
// Multi-channel memory arbiter: NUM_CHANNELS independent FSMs share NUM_CONSUMERS LSU ports.
// Define MEM_CONTROLLER_ROUND_ROBIN_EN for rotating per-channel priority; default is fixed (lowest index wins).
module mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);
    localparam int CW    = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam bit WR_EN = (WRITE_ENABLE != 0);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAITING,
        WRITE_WAITING,
        READ_RELAYING,
        WRITE_RELAYING
    } state_t;

    state_t                     state     [NUM_CHANNELS];
    state_t                     state_nxt [NUM_CHANNELS];
    logic [CW-1:0]              cur       [NUM_CHANNELS];
    logic [CW-1:0]              grant_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]    grant;
    logic [NUM_CHANNELS-1:0]    grant_rd;
    logic [NUM_CONSUMERS-1:0]   claimed;
    logic [NUM_CONSUMERS-1:0]   taken;
    logic [CW-1:0]              scan_idx;
    logic [NUM_CHANNELS-1:0]    mem_wv_q;
    logic [NUM_CONSUMERS-1:0]   wr_ready_q;
`ifdef MEM_CONTROLLER_ROUND_ROBIN_EN
    logic [CW-1:0]              rr_ptr    [NUM_CHANNELS];
`endif

    // Read-only builds tie the write handshake off entirely.
    assign mem_write_valid      = WR_EN ? mem_wv_q   : '0;
    assign consumer_write_ready = WR_EN ? wr_ready_q : '0;

    function automatic logic [CW-1:0] wrap_idx(input int base, input int k);
        int s;
        s = base + k;
        if (s >= NUM_CONSUMERS) s = s - NUM_CONSUMERS;
        return s[CW-1:0];
    endfunction

    // Lower channels claim first; 'taken' accumulates their grants so a later channel skips them.
    always_comb begin
        taken    = claimed;
        grant    = '0;
        grant_rd = '0;
        scan_idx = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            grant_idx[c] = '0;
            state_nxt[c] = state[c];
            case (state[c])
                IDLE: begin
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
`ifdef MEM_CONTROLLER_ROUND_ROBIN_EN
                        scan_idx = wrap_idx(int'(rr_ptr[c]), k);
`else
                        scan_idx = wrap_idx(0, k);
`endif
                        if (!grant[c] && !taken[scan_idx] &&
                            (consumer_read_valid[scan_idx] || (WR_EN && consumer_write_valid[scan_idx]))) begin
                            grant[c]     = 1'b1;
                            grant_idx[c] = scan_idx;
                            grant_rd[c]  = consumer_read_valid[scan_idx];
                        end
                    end
                    if (grant[c]) begin
                        taken[grant_idx[c]] = 1'b1;
                        state_nxt[c] = grant_rd[c] ? READ_WAITING : WRITE_WAITING;
                    end
                end
                READ_WAITING:   if (mem_read_ready[c])               state_nxt[c] = READ_RELAYING;
                WRITE_WAITING:  if (mem_write_ready[c])              state_nxt[c] = WRITE_RELAYING;
                READ_RELAYING:  if (!consumer_read_valid[cur[c]])    state_nxt[c] = IDLE;
                WRITE_RELAYING: if (!consumer_write_valid[cur[c]])   state_nxt[c] = IDLE;
                default:                                             state_nxt[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (reset) state[c] <= IDLE;
            else       state[c] <= state_nxt[c];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            claimed             <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            wr_ready_q          <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
            mem_wv_q            <= '0;
            mem_write_address   <= '0;
            mem_write_data      <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                cur[c] <= '0;
`ifdef MEM_CONTROLLER_ROUND_ROBIN_EN
                rr_ptr[c] <= '0;
`endif
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state[c])
                    IDLE: if (grant[c]) begin
                        cur[c]                 <= grant_idx[c];
                        claimed[grant_idx[c]]  <= 1'b1;
`ifdef MEM_CONTROLLER_ROUND_ROBIN_EN
                        rr_ptr[c] <= (int'(grant_idx[c]) == NUM_CONSUMERS - 1) ? '0 : grant_idx[c] + 1'b1;
`endif
                        if (grant_rd[c]) begin
                            mem_read_valid[c]   <= 1'b1;
                            mem_read_address[c] <= consumer_read_address[grant_idx[c]];
                        end else begin
                            mem_wv_q[c]          <= 1'b1;
                            mem_write_address[c] <= consumer_write_address[grant_idx[c]];
                            mem_write_data[c]    <= consumer_write_data[grant_idx[c]];
                        end
                    end
                    READ_WAITING: if (mem_read_ready[c]) begin
                        mem_read_valid[c]           <= 1'b0;
                        mem_read_address[c]         <= '0;
                        consumer_read_ready[cur[c]] <= 1'b1;
                        consumer_read_data[cur[c]]  <= mem_read_data[c];
                    end
                    WRITE_WAITING: if (mem_write_ready[c]) begin
                        mem_wv_q[c]          <= 1'b0;
                        mem_write_address[c] <= '0;
                        mem_write_data[c]    <= '0;
                        wr_ready_q[cur[c]]   <= 1'b1;
                    end
                    READ_RELAYING: if (!consumer_read_valid[cur[c]]) begin
                        consumer_read_ready[cur[c]] <= 1'b0;
                        claimed[cur[c]]             <= 1'b0;
                    end
                    WRITE_RELAYING: if (!consumer_write_valid[cur[c]]) begin
                        wr_ready_q[cur[c]] <= 1'b0;
                        claimed[cur[c]]    <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mem_controller.sv
// Directed bench: dut1 (1 channel), dut2 (2 channels), dut_ro (read-only) share consumer inputs.
// Memory side is one 4-channel responder: ch0 -> dut1, ch1..2 -> dut2, ch3 -> dut_ro.
module tb_mem_controller;
    localparam int LAT = 3;
    localparam int TMO = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]       rv = '0, wv = '0;
    logic [3:0][7:0]  ra = '0, wa = '0, wd = '0;
    wire  [3:0]       m_rv, m_wv;
    wire  [3:0][7:0]  m_ra, m_wa, m_wd;
    logic [3:0]       m_rr = '0, m_wr = '0;
    logic [3:0][7:0]  m_rd = '0;
    logic [3:0]       c1_rr, c1_wr, c2_rr, c2_wr, cr_rr, cr_wr;
    logic [3:0][7:0]  c1_rd, c2_rd, cr_rd;

    int tests = 0, fails = 0;
    int cnt [4];
    int wr_log [256];
    logic [7:0] wr_dat [256];
    int dup_err, ro_bad, c1_wr_cnt;

    mem_controller #(.NUM_CHANNELS(1)) dut1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra), .consumer_read_ready(c1_rr), .consumer_read_data(c1_rd),
        .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd), .consumer_write_ready(c1_wr),
        .mem_read_valid(m_rv[0:0]), .mem_read_address(m_ra[0:0]), .mem_read_ready(m_rr[0:0]), .mem_read_data(m_rd[0:0]),
        .mem_write_valid(m_wv[0:0]), .mem_write_address(m_wa[0:0]), .mem_write_data(m_wd[0:0]), .mem_write_ready(m_wr[0:0]));

    mem_controller #(.NUM_CHANNELS(2)) dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra), .consumer_read_ready(c2_rr), .consumer_read_data(c2_rd),
        .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd), .consumer_write_ready(c2_wr),
        .mem_read_valid(m_rv[2:1]), .mem_read_address(m_ra[2:1]), .mem_read_ready(m_rr[2:1]), .mem_read_data(m_rd[2:1]),
        .mem_write_valid(m_wv[2:1]), .mem_write_address(m_wa[2:1]), .mem_write_data(m_wd[2:1]), .mem_write_ready(m_wr[2:1]));

    mem_controller #(.NUM_CHANNELS(1), .WRITE_ENABLE(0)) dut_ro (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra), .consumer_read_ready(cr_rr), .consumer_read_data(cr_rd),
        .consumer_write_valid(wv), .consumer_write_address(wa), .consumer_write_data(wd), .consumer_write_ready(cr_wr),
        .mem_read_valid(m_rv[3:3]), .mem_read_address(m_ra[3:3]), .mem_read_ready(m_rr[3:3]), .mem_read_data(m_rd[3:3]),
        .mem_write_valid(m_wv[3:3]), .mem_write_address(m_wa[3:3]), .mem_write_data(m_wd[3:3]), .mem_write_ready(m_wr[3:3]));

    // Fixed-latency memory: ready pulses one cycle, read data = addr ^ 0xB5.
    always @(negedge clk) begin
        if (reset) for (int a = 0; a < 256; a++) wr_log[a] = 0;
        for (int ch = 0; ch < 4; ch++) begin
            if (reset) begin
                m_rr[ch] = 1'b0; m_wr[ch] = 1'b0; cnt[ch] = 0;
            end else if (m_rr[ch] || m_wr[ch]) begin
                m_rr[ch] = 1'b0; m_wr[ch] = 1'b0;
            end else if (m_rv[ch] || m_wv[ch]) begin
                cnt[ch]++;
                if (cnt[ch] == LAT) begin
                    cnt[ch] = 0;
                    if (m_rv[ch]) begin
                        m_rr[ch] = 1'b1;
                        m_rd[ch] = m_ra[ch] ^ 8'hB5;
                    end else begin
                        m_wr[ch] = 1'b1;
                        if (ch == 1 || ch == 2) begin
                            wr_log[m_wa[ch]]++;
                            wr_dat[m_wa[ch]] = m_wd[ch];
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            dup_err = 0; ro_bad = 0; c1_wr_cnt = 0;
        end else begin
            if (m_wv[1] && m_wv[2] && m_wa[1] == m_wa[2]) dup_err++;
            if (m_wv[3] || cr_wr != 4'b0) ro_bad++;
            if (c1_wr != 4'b0) c1_wr_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    function automatic logic sig(input int sel, input int idx);
        case (sel)
            0:       return c1_rr[idx];
            1:       return c1_wr[idx];
            2:       return cr_rr[idx];
            default: return m_rv[idx];
        endcase
    endfunction

    task automatic wait_for(input int sel, input int idx, output int n);
        n = 0;
        do begin tick(); n++; end while (!sig(sel, idx) && n < TMO);
    endtask

    task automatic test_reset();
        rv = 4'hF; wv = 4'hF; ra = {8'h13, 8'h12, 8'h11, 8'h10}; wa = ra; wd = 32'hDEADBEEF;
        reset = 1'b1;
        tick(); tick();
        tests++; if ({m_rv, m_wv, m_ra, m_wa, m_wd} !== '0) begin fails++;
            $display("FAIL reset_mem: got %h want 0", {m_rv, m_wv, m_ra, m_wa, m_wd}); end
        tests++; if ({c1_rr, c1_wr, c1_rd} !== '0) begin fails++;
            $display("FAIL reset_dut1: got %h want 0", {c1_rr, c1_wr, c1_rd}); end
        tests++; if ({c2_rr, c2_wr, c2_rd} !== '0) begin fails++;
            $display("FAIL reset_dut2: got %h want 0", {c2_rr, c2_wr, c2_rd}); end
        tests++; if ({cr_rr, cr_wr, cr_rd} !== '0) begin fails++;
            $display("FAIL reset_ro: got %h want 0", {cr_rr, cr_wr, cr_rd}); end
    endtask

    task automatic test_single_read();
        int n;
        do_reset();
        rv[2] = 1'b1; ra[2] = 8'h10;
        tick();
        tests++; if ({m_rv[0], m_ra[0]} !== {1'b1, 8'h10}) begin fails++;
            $display("FAIL read_issue: got %b/%h want 1/10", m_rv[0], m_ra[0]); end
        wait_for(0, 2, n);
        tests++; if (n !== LAT) begin fails++;
            $display("FAIL read_latency: got %0d want %0d", n, LAT); end
        tests++; if (c1_rd[2] !== 8'hA5) begin fails++;
            $display("FAIL read_data: got %h want a5", c1_rd[2]); end
        tick(); tick();
        tests++; if (c1_rr[2] !== 1'b1) begin fails++;
            $display("FAIL read_ready_hold: got %b want 1", c1_rr[2]); end
        rv[2] = 1'b0;
        tick();
        tests++; if ({c1_rr[2], m_rv[0]} !== 2'b00) begin fails++;
            $display("FAIL read_release: got %b want 00", {c1_rr[2], m_rv[0]}); end
        rv[0] = 1'b1; ra[0] = 8'h11;
        tick();
        tests++; if ({m_rv[0], m_ra[0]} !== {1'b1, 8'h11}) begin fails++;
            $display("FAIL read_back_to_idle: got %b/%h want 1/11", m_rv[0], m_ra[0]); end
        wait_for(0, 0, n);
        rv[0] = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        int n, first, second;
        first = 0;
`ifdef MEM_CONTROLLER_ROUND_ROBIN_EN
        first = 3;
`endif
        second = 3 - first;
        do_reset();
        rv[1] = 1'b1; ra[1] = 8'h21;
        wait_for(0, 1, n);
        rv[1] = 1'b0;
        tick();
        rv[0] = 1'b1; ra[0] = 8'h20;
        rv[3] = 1'b1; ra[3] = 8'h23;
        tick();
        tests++; if ({m_rv[0], m_ra[0]} !== {1'b1, 8'(8'h20 + first)}) begin fails++;
            $display("FAIL contention_first: got %b/%h want 1/%h", m_rv[0], m_ra[0], 8'(8'h20 + first)); end
        wait_for(0, first, n);
        tests++; if (c1_rd[first] !== (8'(8'h20 + first) ^ 8'hB5)) begin fails++;
            $display("FAIL contention_first_data: got %h want %h", c1_rd[first], 8'(8'h20 + first) ^ 8'hB5); end
        rv[first] = 1'b0;
        wait_for(3, 0, n);
        tests++; if ({m_rv[0], m_ra[0]} !== {1'b1, 8'(8'h20 + second)}) begin fails++;
            $display("FAIL contention_second: got %b/%h want 1/%h", m_rv[0], m_ra[0], 8'(8'h20 + second)); end
        wait_for(0, second, n);
        rv[second] = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wv[i] = 1'b1; wa[i] = 8'(8'h40 + i); wd[i] = 8'(8'hC0 + i);
        end
        tick();
        tests++; if (m_wv[2:1] !== 2'b11) begin fails++;
            $display("FAIL b2b_two_grants: got %b want 11", m_wv[2:1]); end
        tests++; if ({m_wa[1], m_wd[1], m_wa[2], m_wd[2]} !== 32'h40C041C1) begin fails++;
            $display("FAIL b2b_first_round: got %h want 40c041c1", {m_wa[1], m_wd[1], m_wa[2], m_wd[2]}); end
        for (int cyc = 0; cyc < 60 && wv != 4'b0; cyc++) begin
            tick();
            for (int i = 0; i < 4; i++) if (c2_wr[i]) wv[i] = 1'b0;
        end
        tick(); tick();
        tests++; if (wv !== 4'b0) begin fails++;
            $display("FAIL b2b_done: pending %b want 0000", wv); end
        tests++; if (dup_err !== 0) begin fails++;
            $display("FAIL b2b_dup_claim: got %0d want 0", dup_err); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (wr_log[8'h40 + i] !== 1 || wr_dat[8'h40 + i] !== 8'(8'hC0 + i)) begin fails++;
                $display("FAIL b2b_write%0d: count %0d data %h want 1/%h", i, wr_log[8'h40 + i], wr_dat[8'h40 + i], 8'(8'hC0 + i)); end
        end
    endtask

    task automatic test_drop_during_wait();
        int n;
        do_reset();
        rv[1] = 1'b1; ra[1] = 8'h31;
        tick();
        tests++; if ({m_rv[0], m_ra[0]} !== {1'b1, 8'h31}) begin fails++;
            $display("FAIL drop_issue: got %b/%h want 1/31", m_rv[0], m_ra[0]); end
        rv[1] = 1'b0;
        wait_for(0, 1, n);
        tests++; if (n !== LAT || c1_rd[1] !== 8'h84) begin fails++;
            $display("FAIL drop_complete: latency %0d data %h want %0d/84", n, c1_rd[1], LAT); end
        tick();
        tests++; if (c1_rr[1] !== 1'b0) begin fails++;
            $display("FAIL drop_release: got %b want 0", c1_rr[1]); end
        rv[0] = 1'b1; ra[0] = 8'h05;
        tick();
        tests++; if ({m_rv[0], m_ra[0]} !== {1'b1, 8'h05}) begin fails++;
            $display("FAIL drop_no_hang: got %b/%h want 1/05", m_rv[0], m_ra[0]); end
        wait_for(0, 0, n);
        rv[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_write();
        int n;
        do_reset();
        wv[2] = 1'b1; wa[2] = 8'h52; wd[2] = 8'h77;
        tick();
        tests++; if ({m_wv[0], m_wa[0], m_wd[0]} !== {1'b1, 8'h52, 8'h77}) begin fails++;
            $display("FAIL rmw_issue: got %b/%h/%h want 1/52/77", m_wv[0], m_wa[0], m_wd[0]); end
        reset = 1'b1; wv[2] = 1'b0;
        tick();
        tests++; if ({m_wv[0], m_wa[0], m_wd[0], m_rv[0], c1_wr, c1_rr} !== '0) begin fails++;
            $display("FAIL rmw_cleared: got %h want 0", {m_wv[0], m_wa[0], m_wd[0], m_rv[0], c1_wr, c1_rr}); end
        reset = 1'b0;
        tick(); tick(); tick();
        tests++; if (c1_wr_cnt !== 0) begin fails++;
            $display("FAIL rmw_no_pulse: got %0d ready cycles want 0", c1_wr_cnt); end
        wv[1] = 1'b1; wa[1] = 8'h61; wd[1] = 8'h99;
        tick();
        tests++; if ({m_wv[0], m_wa[0], m_wd[0]} !== {1'b1, 8'h61, 8'h99}) begin fails++;
            $display("FAIL rmw_new_issue: got %b/%h/%h want 1/61/99", m_wv[0], m_wa[0], m_wd[0]); end
        wait_for(1, 1, n);
        tests++; if (n !== LAT) begin fails++;
            $display("FAIL rmw_new_complete: got latency %0d want %0d", n, LAT); end
        wv[1] = 1'b0;
        tick();
    endtask

    task automatic test_read_only();
        int n;
        do_reset();
        wv[0] = 1'b1; wa[0] = 8'h70; wd[0] = 8'h12;
        rv[1] = 1'b1; ra[1] = 8'h71;
        tick();
        tests++; if ({m_rv[3], m_ra[3]} !== {1'b1, 8'h71}) begin fails++;
            $display("FAIL ro_read_issue: got %b/%h want 1/71", m_rv[3], m_ra[3]); end
        wait_for(2, 1, n);
        tests++; if (n !== LAT || cr_rd[1] !== 8'hC4) begin fails++;
            $display("FAIL ro_read_data: latency %0d data %h want %0d/c4", n, cr_rd[1], LAT); end
        rv[1] = 1'b0;
        repeat (4) tick();
        tests++; if (ro_bad !== 0 || m_rv[3] !== 1'b0) begin fails++;
            $display("FAIL ro_write_ignored: bad cycles %0d mem_rv %b want 0/0", ro_bad, m_rv[3]); end
        wv[0] = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_drop_during_wait();
        test_reset_mid_write();
        test_read_only();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
